// File: rtl/fxu_writeback_buffer.sv
// In-order writeback queue between the fixed-point unit and the register-file write port.
// Push visible on wb_* one cycle later; the producer is never stalled; issue_hold is raised SLACK entries early instead.
module fxu_writeback_buffer #(
   parameter int DEPTH   = 4,
   parameter int SLACK   = 2,
   parameter int THREADS = 1,
   localparam int TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             res_valid,
   input  logic [TID_W-1:0] res_thread,
   input  logic             res_gpr_we,
   input  logic [4:0]       res_gpr_addr,
   input  logic [31:0]      res_gpr_data,
   input  logic             res_cr_we,
   input  logic [2:0]       res_crf,
   input  logic [3:0]       res_cr_data,
   input  logic             res_xer_we,
   input  logic [2:0]       res_xer,
   input  logic             flush,
   input  logic [TID_W-1:0] flush_thread,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [TID_W-1:0] wb_thread,
   output logic             wb_gpr_we,
   output logic [4:0]       wb_gpr_addr,
   output logic [31:0]      wb_gpr_data,
   output logic             wb_cr_we,
   output logic [2:0]       wb_crf,
   output logic [3:0]       wb_cr_data,
   output logic             wb_xer_we,
   output logic [2:0]       wb_xer,
   output logic             issue_hold,
   output logic [CNT_W-1:0] occupancy,
   output logic             overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int HOLD_I = (DEPTH > SLACK) ? (DEPTH - SLACK) : 0;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_I);

   typedef struct packed {
      logic [TID_W-1:0] thr;
      logic             gpr_we;
      logic [4:0]       gpr_addr;
      logic [31:0]      gpr_data;
      logic             cr_we;
      logic [2:0]       crf;
      logic [3:0]       cr_data;
      logic             xer_we;
      logic [2:0]       xer;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [DEPTH-1:0]   kill_q, kill_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;

   entry_t in_ent, head, wb_ent;
   logic   push, pop, accept, full, nonempty, head_vld;

   always_comb begin
      in_ent   = '{thr: res_thread, gpr_we: res_gpr_we, gpr_addr: res_gpr_addr,
                   gpr_data: res_gpr_data, cr_we: res_cr_we, crf: res_crf,
                   cr_data: res_cr_data, xer_we: res_xer_we, xer: res_xer};
      push     = res_valid && (res_gpr_we || res_cr_we || res_xer_we);
      nonempty = (count_q != '0);
      full     = (count_q == FULL_CNT);
      head     = mem_q[rd_ptr_q];
      head_vld = nonempty && !kill_q[rd_ptr_q];
      // A killed head drains silently so flushed work never blocks live entries.
      pop      = (head_vld && wb_ready) || (nonempty && kill_q[rd_ptr_q]);
      accept   = push && (!full || pop);

      mem_d  = mem_q;
      kill_d = kill_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].thr == flush_thread) kill_d[i] = 1'b1;
         end
      end
      if (pop) kill_d[rd_ptr_q] = 1'b0;
      if (accept) begin
         mem_d[wr_ptr_q]  = in_ent;
         kill_d[wr_ptr_q] = flush && (res_thread == flush_thread);
      end

      rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

      count_d = count_q;
      if (accept && !pop)      count_d = count_q + CNT_W'(1);
      else if (!accept && pop) count_d = count_q - CNT_W'(1);

      overflow_d = overflow_q || (push && full && !pop);

      wb_ent = head_vld ? head : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kill_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         kill_q     <= kill_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign wb_valid    = head_vld;
   assign wb_thread   = wb_ent.thr;
   assign wb_gpr_we   = wb_ent.gpr_we;
   assign wb_gpr_addr = wb_ent.gpr_addr;
   assign wb_gpr_data = wb_ent.gpr_data;
   assign wb_cr_we    = wb_ent.cr_we;
   assign wb_crf      = wb_ent.crf;
   assign wb_cr_data  = wb_ent.cr_data;
   assign wb_xer_we   = wb_ent.xer_we;
   assign wb_xer      = wb_ent.xer;
   assign issue_hold  = (count_q >= HOLD_CNT);
   assign occupancy   = count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_fxu_writeback_buffer.sv
// Directed bench for fxu_writeback_buffer with a scoreboard queue of expected head entries.
module tb_fxu_writeback_buffer;

   logic        clk, reset;
   logic        res_valid, res_thread, res_gpr_we, res_cr_we, res_xer_we;
   logic [4:0]  res_gpr_addr;
   logic [31:0] res_gpr_data;
   logic [2:0]  res_crf, res_xer;
   logic [3:0]  res_cr_data;
   logic        flush, flush_thread, wb_ready;
   logic        wb_valid, wb_thread, wb_gpr_we, wb_cr_we, wb_xer_we;
   logic [4:0]  wb_gpr_addr;
   logic [31:0] wb_gpr_data;
   logic [2:0]  wb_crf, wb_xer;
   logic [3:0]  wb_cr_data;
   logic        issue_hold, overflow;
   logic [2:0]  occupancy;

   typedef struct packed {
      logic        thr;
      logic        gw;
      logic [4:0]  ga;
      logic [31:0] gd;
      logic        cw;
      logic [2:0]  cf;
      logic [3:0]  cd;
      logic        xw;
      logic [2:0]  x;
   } ent_t;

   ent_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   fxu_writeback_buffer #(.DEPTH(4), .SLACK(2), .THREADS(2)) dut (
      .clk(clk), .reset(reset),
      .res_valid(res_valid), .res_thread(res_thread),
      .res_gpr_we(res_gpr_we), .res_gpr_addr(res_gpr_addr), .res_gpr_data(res_gpr_data),
      .res_cr_we(res_cr_we), .res_crf(res_crf), .res_cr_data(res_cr_data),
      .res_xer_we(res_xer_we), .res_xer(res_xer),
      .flush(flush), .flush_thread(flush_thread),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_thread(wb_thread),
      .wb_gpr_we(wb_gpr_we), .wb_gpr_addr(wb_gpr_addr), .wb_gpr_data(wb_gpr_data),
      .wb_cr_we(wb_cr_we), .wb_crf(wb_crf), .wb_cr_data(wb_cr_data),
      .wb_xer_we(wb_xer_we), .wb_xer(wb_xer),
      .issue_hold(issue_hold), .occupancy(occupancy), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t mk(logic t, logic gw, logic [4:0] ga, logic [31:0] gd,
                               logic cw, logic [2:0] cf, logic [3:0] cd, logic xw, logic [2:0] x);
      mk = {t, gw, ga, gd, cw, cf, cd, xw, x};
   endfunction

   function automatic ent_t obs();
      obs = {wb_thread, wb_gpr_we, wb_gpr_addr, wb_gpr_data, wb_cr_we, wb_crf,
             wb_cr_data, wb_xer_we, wb_xer};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(ent_t e);
      res_valid    = 1'b1;
      res_thread   = e.thr;
      res_gpr_we   = e.gw;
      res_gpr_addr = e.ga;
      res_gpr_data = e.gd;
      res_cr_we    = e.cw;
      res_crf      = e.cf;
      res_cr_data  = e.cd;
      res_xer_we   = e.xw;
      res_xer      = e.x;
   endtask

   task automatic idle();
      drive('0);
      res_valid = 1'b0;
   endtask

   task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
      end
   endtask

   task automatic chk_head(string tag);
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
      end else begin
         chk({tag, "_vld"}, 64'(wb_valid), 64'd1);
         chk(tag, 64'(obs()), 64'(sbq[0]));
      end
   endtask

   initial begin
      ent_t e;
      ent_t keep[$];
      reset = 1'b0; wb_ready = 1'b0; flush = 1'b0; flush_thread = 1'b0;
      idle();
      #1;
      chk("rst_vld", 64'(wb_valid), 0);
      chk("rst_occ", 64'(occupancy), 0);
      chk("rst_ovf", 64'(overflow), 0);
      chk("rst_hold", 64'(issue_hold), 0);
      chk("rst_fields", 64'(obs()), 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // single push, one-cycle latency
      wb_ready = 1'b1;
      e = mk(0, 1, 5'd5, 32'h12345678, 0, 0, 0, 0, 0);
      drive(e); sbq.push_back(e);
      chk("no_bypass", 64'(wb_valid), 0);
      tick(); idle();
      chk_head("single");
      void'(sbq.pop_front());
      tick();
      chk("single_occ0", 64'(occupancy), 0);
      chk("single_vld0", 64'(wb_valid), 0);

      // fill to full, hold threshold, overflow
      wb_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         e = mk(0, 1, 5'(k + 1), $urandom, k[0], 3'(k), 4'(k + 3), k[1], 3'(7 - k));
         drive(e); sbq.push_back(e);
         tick();
         chk($sformatf("fill_occ%0d", k), 64'(occupancy), 64'(k + 1));
         chk($sformatf("fill_hold%0d", k), 64'(issue_hold), 64'((k + 1) >= 2));
         chk_head($sformatf("fill_head%0d", k));
      end
      drive(mk(1, 1, 5'd30, 32'hDEADBEEF, 1, 3'd6, 4'hF, 1, 3'd5));
      tick(); idle();
      chk("ovf_set", 64'(overflow), 1);
      chk("ovf_occ", 64'(occupancy), 4);
      chk_head("ovf_head");

      // push and pop together at full
      e = mk(1, 0, 5'd9, 32'h0, 1, 3'd2, 4'hA, 1, 3'd3);
      drive(e); wb_ready = 1'b1;
      chk_head("full_pp_head");
      void'(sbq.pop_front());
      sbq.push_back(e);
      tick(); idle(); wb_ready = 1'b0;
      chk("full_pp_occ", 64'(occupancy), 4);
      chk("ovf_sticky", 64'(overflow), 1);
      chk_head("full_pp_next");
      wb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_head($sformatf("drain%0d", k));
         void'(sbq.pop_front());
         tick();
      end
      chk("drain_occ", 64'(occupancy), 0);
      chk("drain_vld", 64'(wb_valid), 0);
      chk("drain_hold", 64'(issue_hold), 0);

      // result without write enables is discarded
      wb_ready = 1'b0;
      drive(mk(0, 0, 5'd7, 32'h55AA55AA, 0, 3'd1, 4'h1, 0, 3'd1));
      tick(); idle();
      chk("nowe_occ", 64'(occupancy), 0);
      chk("nowe_vld", 64'(wb_valid), 0);

      // flush thread 0 out of T0,T1,T0,T1
      for (int k = 0; k < 4; k++) begin
         e = mk(k[0], 1, 5'(10 + k), $urandom, 0, 0, 0, 1, 3'(k));
         drive(e); sbq.push_back(e);
         tick();
      end
      idle();
      chk("fl_occ_pre", 64'(occupancy), 4);
      flush = 1'b1; flush_thread = 1'b0;
      tick(); flush = 1'b0;
      keep = {};
      foreach (sbq[i]) if (sbq[i].thr != 1'b0) keep.push_back(sbq[i]);
      sbq = keep;
      chk("fl_vld0", 64'(wb_valid), 0);
      chk("fl_occ4", 64'(occupancy), 4);
      tick();
      chk("fl_occ3", 64'(occupancy), 3);
      chk_head("fl_t1_head");
      tick();
      chk_head("fl_t1_hold");
      wb_ready = 1'b1;
      chk_head("fl_t1_pop");
      void'(sbq.pop_front());
      tick();
      chk("fl_occ2", 64'(occupancy), 2);
      chk("fl_vld_kill2", 64'(wb_valid), 0);
      tick();
      chk("fl_occ1", 64'(occupancy), 1);
      chk_head("fl_last");
      void'(sbq.pop_front());
      tick();
      chk("fl_occ0", 64'(occupancy), 0);

      // push from the flushed thread in the flush cycle lands killed
      drive(mk(0, 1, 5'd20, 32'hCAFEF00D, 0, 0, 0, 0, 0));
      flush = 1'b1; flush_thread = 1'b0;
      tick(); idle(); flush = 1'b0;
      chk("flpush_occ", 64'(occupancy), 1);
      chk("flpush_vld", 64'(wb_valid), 0);
      tick();
      chk("flpush_occ0", 64'(occupancy), 0);

      // handshake completing in the flush cycle stands
      e = mk(1, 1, 5'd21, 32'h0BADF00D, 1, 3'd4, 4'h6, 0, 0);
      drive(e); sbq.push_back(e);
      tick(); idle();
      flush = 1'b1; flush_thread = 1'b1;
      chk_head("flhs_head");
      void'(sbq.pop_front());
      tick(); flush = 1'b0;
      chk("flhs_occ", 64'(occupancy), 0);
      chk("flhs_vld", 64'(wb_valid), 0);

      // asynchronous reset mid-stream
      wb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e = mk(1, 1, 5'(24 + k), $urandom, 0, 0, 0, 0, 0);
         drive(e); sbq.push_back(e);
         tick();
      end
      idle();
      chk("mid_occ3", 64'(occupancy), 3);
      chk("mid_ovf", 64'(overflow), 1);
      chk("mid_hold", 64'(issue_hold), 1);
      #2; reset = 1'b0; #1;
      chk("arst_vld", 64'(wb_valid), 0);
      chk("arst_occ", 64'(occupancy), 0);
      chk("arst_ovf", 64'(overflow), 0);
      chk("arst_hold", 64'(issue_hold), 0);
      chk("arst_fields", 64'(obs()), 0);
      sbq.delete();
      #2; reset = 1'b1;
      tick();
      wb_ready = 1'b1;
      e = mk(0, 0, 5'd3, 32'h0, 1, 3'd7, 4'h9, 1, 3'd6);
      drive(e); sbq.push_back(e);
      tick(); idle();
      chk("post_occ1", 64'(occupancy), 1);
      chk_head("post_head");
      void'(sbq.pop_front());
      tick();
      chk("post_occ0", 64'(occupancy), 0);
      chk("post_vld0", 64'(wb_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
